// File: rtl/seg_scan_ctrl.sv
// Eight-digit multiplexed seven-segment scanner: each digit is driven for DIV
// cycles followed by one blank cycle; frame_done marks the blank after digit 7.
module seg_scan_ctrl #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       wr_en,
  input  logic [2:0] wr_idx,
  input  logic [3:0] wr_data,
  input  logic       mask_wr,
  input  logic [7:0] mask_data,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       frame_done,
  output logic       nz
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {OFF, SCAN, GAP} state_t;

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       d_q [8];
  logic [3:0]       d_d [8];
  logic [7:0]       mask_q, mask_d;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b0111111;
      4'h1: hex7 = 7'b0000110;
      4'h2: hex7 = 7'b1011011;
      4'h3: hex7 = 7'b1001111;
      4'h4: hex7 = 7'b1100110;
      4'h5: hex7 = 7'b1101101;
      4'h6: hex7 = 7'b1111101;
      4'h7: hex7 = 7'b0000111;
      4'h8: hex7 = 7'b1111111;
      4'h9: hex7 = 7'b1101111;
      4'hA: hex7 = 7'b1110111;
      4'hB: hex7 = 7'b1111100;
      4'hC: hex7 = 7'b0111001;
      4'hD: hex7 = 7'b1011110;
      4'hE: hex7 = 7'b1111001;
      default: hex7 = 7'b1110001;
    endcase
  endfunction

  // Register-file updates are independent of the scan state machine.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    for (int i = 0; i < 8; i++) d_d[i] = d_q[i];
    if (wr_en) d_d[wr_idx] = wr_data;
    mask_d = mask_wr ? mask_data : mask_q;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= OFF;
      idx_q   <= '0;
      cnt_q   <= '0;
      mask_q  <= '0;
      // NOTE: the digit store is a handful of flops that must read zero after
      // reset (nz depends on it), so it is reset rather than left as a RAM.
      for (int i = 0; i < 8; i++) d_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      for (int i = 0; i < 8; i++) d_q[i] <= d_d[i];
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      OFF: begin
        if (en) begin
          state_d = SCAN;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      SCAN: begin
        if (!en) begin
          state_d = OFF;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      GAP: begin
        if (!en) begin
          state_d = OFF;
          idx_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = SCAN;
          idx_d   = idx_q + 3'd1;
        end
      end
      default: begin
        state_d = OFF;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from registered state only; masked digits blank but keep their slot.
  always_comb begin
    an         = '0;
    seg        = '0;
    frame_done = 1'b0;
    nz         = 1'b0;
    case (state_q)
      SCAN: begin
        if (mask_q[idx_q]) begin
          an  = 8'd1 << idx_q;
          seg = hex7(d_q[idx_q]);
        end
      end
      GAP:     frame_done = (idx_q == 3'd7);
      default: ;
    endcase
    for (int i = 0; i < 8; i++) nz = nz | (d_q[i] != 4'h0);
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a frame-position model predicts each
// cycle's outputs; a monitor pops and compares them one cycle at a time.
module tb_seg_scan_ctrl;
  localparam int DIV   = 4;
  localparam int PER   = DIV + 1;
  localparam int FRAME = 8 * PER;

  logic       clk = 1'b0;
  logic       rst, en, wr_en, mask_wr;
  logic [2:0] wr_idx;
  logic [3:0] wr_data;
  logic [7:0] mask_data;
  logic [7:0] an;
  logic [6:0] seg;
  logic       frame_done, nz;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIV(DIV)) dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_idx(wr_idx),
    .wr_data(wr_data), .mask_wr(mask_wr), .mask_data(mask_data),
    .an(an), .seg(seg), .frame_done(frame_done), .nz(nz)
  );

  logic [6:0] hex7_tab [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

  // Model: display is either off, or at time m_t cycles into a repeating frame.
  bit         m_active;
  int         m_t;
  logic [3:0] m_d [8];
  logic [7:0] m_mask;

  logic [16:0] exp_q [$];
  bit          running;
  int          n_checks, n_pass;

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got an=%h seg=%b fd=%b nz=%b, expected an=%h seg=%b fd=%b nz=%b",
                  name, $time, act[16:9], act[8:2], act[1], act[0],
                  exp[16:9], exp[8:2], exp[1], exp[0]);
  endtask

  function automatic int cur_dig();
    return (m_t % FRAME) / PER;
  endfunction

  function automatic int cur_slot();
    return (m_t % FRAME) % PER;
  endfunction

  function automatic logic [16:0] model_out();
    logic [7:0] e_an  = '0;
    logic [6:0] e_seg = '0;
    logic       e_fd  = 1'b0;
    logic       e_nz  = 1'b0;
    for (int i = 0; i < 8; i++) if (m_d[i] != 0) e_nz = 1'b1;
    if (m_active) begin
      if (cur_slot() == DIV) e_fd = (cur_dig() == 7);
      else if (m_mask[cur_dig()]) begin
        e_an  = 8'(1 << cur_dig());
        e_seg = hex7_tab[m_d[cur_dig()]];
      end
    end
    return {e_an, e_seg, e_fd, e_nz};
  endfunction

  task automatic model_step();
    if (rst) begin
      m_active = 0;
      m_t      = 0;
      m_mask   = '0;
      for (int i = 0; i < 8; i++) m_d[i] = '0;
    end else begin
      if (wr_en) m_d[wr_idx] = wr_data;
      if (mask_wr) m_mask = mask_data;
      if (!en) begin
        m_active = 0;
        m_t      = 0;
      end else if (!m_active) begin
        m_active = 1;
        m_t      = 0;
      end else begin
        m_t = (m_t + 1) % FRAME;
      end
    end
  endtask

  // Drive one cycle of inputs, predict the outputs after the next edge.
  task automatic cycle(input logic r, input logic e, input logic we, input logic [2:0] wi,
                       input logic [3:0] wd, input logic mw, input logic [7:0] md);
    logic prev_rst;
    @(negedge clk);
    prev_rst = rst;
    rst = r; en = e; wr_en = we; wr_idx = wi; wr_data = wd; mask_wr = mw; mask_data = md;
    if (r && !prev_rst) begin
      #1 check("async_rst", {an, seg, frame_done, nz}, 17'h0);
    end
    model_step();
    exp_q.push_back(model_out());
    running = 1;
  endtask

  task automatic run(input int n, input logic e);
    for (int k = 0; k < n; k++) cycle(1'b0, e, 1'b0, 3'd0, 4'd0, 1'b0, 8'h00);
  endtask

  task automatic wr(input logic e, input logic [2:0] i, input logic [3:0] v);
    cycle(1'b0, e, 1'b1, i, v, 1'b0, 8'h00);
  endtask

  task automatic wait_pos(input int dg, input int sl);
    int k = 0;
    while (!(m_active && cur_dig() == dg && cur_slot() == sl) && k < 2 * FRAME) begin
      run(1, 1'b1);
      k++;
    end
    n_checks++;
    if (k < 2 * FRAME) n_pass++;
    else $display("FAIL wait_pos digit %0d slot %0d: not reached in %0d cycles", dg, sl, k);
  endtask

  always @(posedge clk) begin
    #1;
    if (running) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard_empty @%0t: no expected entry for this cycle", $time);
      end else begin
        check("scan_out", {an, seg, frame_done, nz}, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_data = '0;
    mask_wr = 1'b0; mask_data = '0;
    m_active = 0; m_t = 0; m_mask = '0;
    for (int i = 0; i < 8; i++) m_d[i] = '0;
    #1 check("reset_state", {an, seg, frame_done, nz}, 17'h0);
    cycle(1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 8'h00);
    cycle(1'b1, 1'b0, 1'b0, 3'd0, 4'd0, 1'b0, 8'h00);

    // d[i]=i, all digits enabled, two full frames.
    for (int i = 0; i < 8; i++) wr(1'b0, 3'(i), 4'(i));
    cycle(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1, 8'hFF);
    run(2 * FRAME + 3, 1'b1);

    // Mask 0x05 with all digits = 8.
    run(1, 1'b0);
    for (int i = 0; i < 8; i++) wr(1'b0, 3'(i), 4'h8);
    cycle(1'b0, 1'b0, 1'b0, 3'd0, 4'd0, 1'b1, 8'h05);
    run(FRAME + 2, 1'b1);

    // Live rewrite of digit 3 from E to F mid-dwell.
    cycle(1'b0, 1'b0, 1'b1, 3'd3, 4'hE, 1'b1, 8'hFF);
    wait_pos(3, 1);
    wr(1'b1, 3'd3, 4'hF);
    run(FRAME, 1'b1);

    // Drop en mid digit 5, then re-raise.
    wait_pos(5, 2);
    run(3, 1'b0);
    run(PER + 2, 1'b1);

    // Reset pulse mid-frame, then restart.
    wait_pos(7, 1);
    cycle(1'b1, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 8'h00);
    cycle(1'b1, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 8'h00);
    run(FRAME, 1'b1);

    // nz tracking on digit 7.
    wr(1'b1, 3'd7, 4'h1);
    run(2, 1'b1);
    wr(1'b1, 3'd7, 4'h0);
    run(2, 1'b1);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 39) != 0),
            ($urandom_range(0, 7) == 0), 3'($urandom), 4'($urandom),
            ($urandom_range(0, 29) == 0), 8'($urandom));
    end
    cycle(1'b0, 1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 8'h00);

    @(posedge clk);
    #2 running = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL provide parameter DIV, default 4: number of cycles each digit is driven; legal range 2..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port en  input  1  display enable; 0 = blank and idle.
REQ-005 SHALL have port wr_en  input  1  digit register write strobe.
REQ-006 SHALL have port wr_idx  input  3  digit register index for a write.
REQ-007 SHALL have port wr_data  input  4  hex value for a write.
REQ-008 SHALL have port mask_wr  input  1  digit-enable mask write strobe.
REQ-009 SHALL have port mask_data  input  8  new digit-enable mask; bit i enables digit i.
REQ-010 SHALL have port an  output  8  one-hot digit select, active-high.
REQ-011 SHALL have port seg  output  7  segment pattern, active-high, bit order {g,f,e,d,c,b,a}.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse at end of each full 8-digit frame.
REQ-013 SHALL have port nz  output  1  1 iff any digit register is nonzero.

Function
REQ-014 SHALL hold eight 4-bit digit registers d[0..7], an 8-bit mask register, a 3-bit scan index idx, a dwell counter cnt sized for DIV-1, and state in {OFF, SCAN, GAP}.
REQ-015 SHALL, on a clock edge with wr_en=1, load d[wr_idx] <= wr_data, independent of state and en.
REQ-016 SHALL, on a clock edge with mask_wr=1, load mask <= mask_data, independent of state and en.
REQ-017 SHALL decode an, seg, frame_done and nz combinationally from registered state only; there SHALL be no combinational path from any input to any output.
REQ-018 SHALL, in OFF: an=0, seg=0; next state SCAN with idx=0, cnt=0 when en=1, else remain OFF.
REQ-019 SHALL, in SCAN: an = one-hot(idx) and seg = hex7(d[idx]) when mask[idx]=1; an=0 and seg=0 when mask[idx]=0; masked digits still consume their full time slot.
REQ-020 SHALL, in SCAN, increment cnt each cycle; when cnt==DIV-1, go to GAP and clear cnt.
REQ-021 SHALL, in GAP (exactly 1 cycle): an=0, seg=0; then go to SCAN with idx <= idx+1 mod 8 (7 wraps to 0).
REQ-022 SHALL assert frame_done for exactly the GAP cycle with idx==7; per-digit period is DIV+1 cycles, frame period 8*(DIV+1) cycles.
REQ-023 SHALL, when en=0 is sampled in SCAN or GAP, go to OFF at that edge with idx=0 and cnt=0; digit and mask registers are unaffected.
REQ-024 SHALL use hex7: 0=0111111 1=0000110 2=1011011 3=1001111 4=1100110 5=1101101 6=1111101 7=0000111 8=1111111 9=1101111 A=1110111 B=1111100 C=0111001 D=1011110 E=1111001 F=1110001.
REQ-025 SHALL, on a write to the currently displayed digit, show the new pattern from the cycle after the write edge, with no change to idx/cnt timing.
REQ-026 SHALL, on simultaneous wr_en, mask_wr and a state transition at one edge, apply all three updates at that edge.

Reset
REQ-027 SHALL, while rst=1, immediately force state=OFF, idx=0, cnt=0, d[0..7]=0, mask=0, giving an=0, seg=0, frame_done=0, nz=0.
REQ-028 SHALL, on rst deassertion, begin operation on the first following rising edge; rst asserted mid-frame SHALL abort the frame with no frame_done pulse.

Verification
REQ-029 SHALL cover: reset, mask=FF, d[i]=i, en=1, DIV=4 -> an=01 seg=0111111 for 4 cycles, 1 blank cycle, an=02 seg=0000110, ...; frame_done once every 40 cycles.
REQ-030 SHALL cover: mask=0x05, d all =8 -> only an=01 and an=04 with seg=1111111; other slots blank but same 5-cycle duration.
REQ-031 SHALL cover: write d[3]=F during digit-3 dwell -> seg changes 1111001->1110001 next cycle, cnt timing unchanged.
REQ-032 SHALL cover: en dropped mid-digit 5 -> an=0 next cycle; en re-raised -> scan restarts at an=01.
REQ-033 SHALL cover: rst pulsed mid-frame -> an=0, seg=0, nz=0 asynchronously; no frame_done; restart from digit 0 after en.
REQ-034 SHALL cover: all d=0 -> nz=0; single write d[7]=1 -> nz=1 next cycle; write d[7]=0 -> nz=0.
